// File: rtl/mram_arbiter_ctrl.sv
// Two-port round-robin arbiter and strobe sequencer for a 16-bit async MRAM.
// Partial-byte writes run a read phase then a write phase with the merged word.
module mram_arbiter_ctrl #(
  parameter int T_SU    = 1,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_be,
  input  logic [11:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_be,
  input  logic [11:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_ack,
  output logic [15:0] rdata,
  output logic [15:0] mem_a,
  output logic        mem_e_n,
  output logic        mem_g_n,
  output logic        mem_w_n,
  output logic        mem_lb_n,
  output logic        mem_ub_n,
  output logic [15:0] mem_dq_o,
  output logic        mem_dq_oe,
  input  logic [15:0] mem_dq_i
);
  // state | meaning
  // IDLE  | chip deselected, arbitrate between pending requests
  // SETUP | address/data stable with E_n low, no strobe yet
  // ACC   | G_n (read phase) or W_n (write phase) low
  // HOLD  | strobes released, E_n low; last HOLD of an op acks
  typedef enum logic [1:0] {IDLE, SETUP, ACC, HOLD} state_t;

  localparam logic [3:0] SU_LOAD = 4'(T_SU - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        wr_phase, wr_phase_nx;
  logic        rmw, rmw_nx;
  logic        nop, nop_nx;
  logic        last, last_nx;
  logic        sel, sel_nx;
  logic [1:0]  be_q, be_nx;
  logic [15:0] data_q, data_nx;
  logic [15:0] rbuf, rbuf_nx;
  logic [15:0] merged;
  logic        req0, req1, pick;
  logic        g_we;
  logic [1:0]  g_be;
  logic [11:0] g_addr;
  logic [15:0] g_wdata;
  logic        ack0_nx, ack1_nx;
  logic [15:0] rdata_nx, a_nx, dq_o_nx;
  logic        e_n_nx, g_n_nx, w_n_nx, lb_n_nx, ub_n_nx, oe_nx;

  always_comb begin
    // a port whose ack is showing is finishing its handshake, not re-requesting
    req0    = p0_req & ~p0_ack;
    req1    = p1_req & ~p1_ack;
    pick    = (req0 & req1) ? ~last : req1;
    g_we    = pick ? p1_we    : p0_we;
    g_be    = pick ? p1_be    : p0_be;
    g_addr  = pick ? p1_addr  : p0_addr;
    g_wdata = pick ? p1_wdata : p0_wdata;
    merged  = {be_q[1] ? data_q[15:8] : rbuf[15:8], be_q[0] ? data_q[7:0] : rbuf[7:0]};

    state_nx    = state;
    cnt_nx      = cnt;
    wr_phase_nx = wr_phase;
    rmw_nx      = rmw;
    nop_nx      = nop;
    last_nx     = last;
    sel_nx      = sel;
    be_nx       = be_q;
    data_nx     = data_q;
    rbuf_nx     = rbuf;
    ack0_nx     = 1'b0;
    ack1_nx     = 1'b0;
    rdata_nx    = rdata;
    a_nx        = mem_a;
    e_n_nx      = mem_e_n;
    g_n_nx      = mem_g_n;
    w_n_nx      = mem_w_n;
    lb_n_nx     = mem_lb_n;
    ub_n_nx     = mem_ub_n;
    dq_o_nx     = mem_dq_o;
    oe_nx       = mem_dq_oe;

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          last_nx = pick;
          sel_nx  = pick;
          be_nx   = g_be;
          data_nx = g_wdata;
          if (g_be == 2'b00) begin
            nop_nx      = 1'b1;
            rmw_nx      = 1'b0;
            wr_phase_nx = 1'b0;
            state_nx    = HOLD;
          end else begin
            nop_nx      = 1'b0;
            wr_phase_nx = g_we & (g_be == 2'b11);
            rmw_nx      = g_we & (g_be != 2'b11);
            state_nx    = SETUP;
            cnt_nx      = SU_LOAD;
            a_nx        = {4'h0, g_addr};
            e_n_nx      = 1'b0;
            lb_n_nx     = 1'b0;
            ub_n_nx     = 1'b0;
            if (g_we & (g_be == 2'b11)) begin
              dq_o_nx = g_wdata;
              oe_nx   = 1'b1;
            end
          end
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_nx = ACC;
          cnt_nx   = wr_phase ? WR_LOAD : RD_LOAD;
          g_n_nx   = wr_phase;
          w_n_nx   = ~wr_phase;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ACC: begin
        if (cnt == 4'd0) begin
          state_nx = HOLD;
          g_n_nx   = 1'b1;
          w_n_nx   = 1'b1;
          if (!wr_phase) rbuf_nx = mem_dq_i;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (rmw & ~wr_phase) begin
          wr_phase_nx = 1'b1;
          data_nx     = merged;
          dq_o_nx     = merged;
          oe_nx       = 1'b1;
          state_nx    = SETUP;
          cnt_nx      = SU_LOAD;
        end else begin
          state_nx = IDLE;
          a_nx     = 16'h0000;
          e_n_nx   = 1'b1;
          lb_n_nx  = 1'b1;
          ub_n_nx  = 1'b1;
          dq_o_nx  = 16'h0000;
          oe_nx    = 1'b0;
          ack0_nx  = ~sel;
          ack1_nx  = sel;
          if (!nop) rdata_nx = wr_phase ? data_q : rbuf;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_phase  <= 1'b0;
      rmw       <= 1'b0;
      nop       <= 1'b0;
      last      <= 1'b1;
      sel       <= 1'b0;
      be_q      <= 2'b00;
      data_q    <= 16'h0000;
      rbuf      <= 16'h0000;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      rdata     <= 16'h0000;
      mem_a     <= 16'h0000;
      mem_e_n   <= 1'b1;
      mem_g_n   <= 1'b1;
      mem_w_n   <= 1'b1;
      mem_lb_n  <= 1'b1;
      mem_ub_n  <= 1'b1;
      mem_dq_o  <= 16'h0000;
      mem_dq_oe <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      wr_phase  <= wr_phase_nx;
      rmw       <= rmw_nx;
      nop       <= nop_nx;
      last      <= last_nx;
      sel       <= sel_nx;
      be_q      <= be_nx;
      data_q    <= data_nx;
      rbuf      <= rbuf_nx;
      p0_ack    <= ack0_nx;
      p1_ack    <= ack1_nx;
      rdata     <= rdata_nx;
      mem_a     <= a_nx;
      mem_e_n   <= e_n_nx;
      mem_g_n   <= g_n_nx;
      mem_w_n   <= w_n_nx;
      mem_lb_n  <= lb_n_nx;
      mem_ub_n  <= ub_n_nx;
      mem_dq_o  <= dq_o_nx;
      mem_dq_oe <= oe_nx;
    end
  end
endmodule

// File: tb/tb_mram_arbiter_ctrl.sv
// Bench for mram_arbiter_ctrl: behavioural MRAM chip, word-level reference model,
// expected-ack queue popped by an independent monitor, plus strobe protocol checks.
module tb_mram_arbiter_ctrl;
  localparam int T_SU    = 1;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;

  typedef struct packed {
    logic        we;
    logic [1:0]  be;
    logic [11:0] addr;
    logic [15:0] wdata;
  } txn_t;

  typedef struct {
    int          port;
    int          cyc;
    bit          chk_rd;
    logic [15:0] rd;
  } exp_t;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [1:0]  p0_be = 2'b00, p1_be = 2'b00;
  logic [11:0] p0_addr = 12'h0, p1_addr = 12'h0;
  logic [15:0] p0_wdata = 16'h0, p1_wdata = 16'h0;
  logic        p0_ack, p1_ack;
  logic [15:0] rdata, mem_a, mem_dq_o, mem_dq_i;
  logic        mem_e_n, mem_g_n, mem_w_n, mem_lb_n, mem_ub_n, mem_dq_oe;

  logic [15:0] chip_mem [0:4095] = '{default: 16'h0000};
  logic [15:0] mem_ref  [0:4095] = '{default: 16'h0000};
  exp_t        exp_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          e_low_cnt = 0;
  bit          m_last = 1'b1;
  bit          in_rst_test = 1'b0;

  always #5 SIM_CLK = ~SIM_CLK;
  always @(posedge SIM_CLK) cyc <= cyc + 1;

  mram_arbiter_ctrl #(.T_SU(T_SU), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack),
    .rdata(rdata), .mem_a(mem_a), .mem_e_n(mem_e_n), .mem_g_n(mem_g_n),
    .mem_w_n(mem_w_n), .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n),
    .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe), .mem_dq_i(mem_dq_i)
  );

  // chip: drives DQ while selected and output-enabled, stores the whole word under W_n
  assign mem_dq_i = (!mem_e_n && !mem_g_n) ? chip_mem[mem_a[11:0]] : 16'h0000;
  always @(posedge SIM_CLK)
    if (!mem_e_n && !mem_w_n && mem_dq_oe) chip_mem[mem_a[11:0]] <= mem_dq_o;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int lat(txn_t t);
    if (t.be == 2'b00) return 1;
    if (!t.we) return T_SU + RD_WAIT + 1;
    if (t.be == 2'b11) return T_SU + WR_WAIT + 1;
    return (T_SU + RD_WAIT + 1) + (T_SU + WR_WAIT + 1);
  endfunction

  function automatic void model_push(int port, txn_t t, int ack_cyc);
    exp_t x;
    logic [15:0] m;
    m        = mem_ref[t.addr];
    x.port   = port;
    x.cyc    = ack_cyc;
    x.chk_rd = (t.be != 2'b00);
    x.rd     = m;
    if (t.we && t.be != 2'b00) begin
      if (t.be[0]) m[7:0]  = t.wdata[7:0];
      if (t.be[1]) m[15:8] = t.wdata[15:8];
      mem_ref[t.addr] = m;
      x.rd = m;
    end
    exp_q.push_back(x);
  endfunction

  function automatic txn_t mk(logic we, logic [1:0] be, logic [11:0] addr, logic [15:0] wdata);
    txn_t t;
    t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              12'h010 + 12'($urandom_range(0, 7)), 16'($urandom));
  endfunction

  task automatic issue(input bit u0, input bit u1, input txn_t t0, input txn_t t1, input bit scramble);
    int e, n, first, c1;
    bit d0, d1;
    txn_t tf, ts;
    @(negedge SIM_CLK);
    e = cyc + 1;
    if (u0 && u1) begin
      first = m_last ? 0 : 1;
      tf = (first == 0) ? t0 : t1;
      ts = (first == 0) ? t1 : t0;
      c1 = e + lat(tf);
      model_push(first, tf, c1);
      model_push(1 - first, ts, c1 + 1 + lat(ts));
      m_last = (first == 0);
    end else if (u0) begin
      model_push(0, t0, e + lat(t0));
      m_last = 1'b0;
    end else begin
      model_push(1, t1, e + lat(t1));
      m_last = 1'b1;
    end
    if (u0) begin
      p0_we = t0.we; p0_be = t0.be; p0_addr = t0.addr; p0_wdata = t0.wdata; p0_req = 1'b1;
    end
    if (u1) begin
      p1_we = t1.we; p1_be = t1.be; p1_addr = t1.addr; p1_wdata = t1.wdata; p1_req = 1'b1;
    end
    d0 = !u0; d1 = !u1; n = 0;
    while (!(d0 && d1) && n < 60) begin
      @(negedge SIM_CLK);
      n++;
      if (scramble && n == 1) begin
        p0_wdata = ~p0_wdata; p0_addr = p0_addr ^ 12'h001; p0_be = ~p0_be; p0_we = ~p0_we;
        p1_wdata = ~p1_wdata; p1_addr = p1_addr ^ 12'h001; p1_be = ~p1_be; p1_we = ~p1_we;
      end
      if (p0_ack && u0) begin p0_req = 1'b0; d0 = 1'b1; end
      if (p1_ack && u1) begin p1_req = 1'b0; d1 = 1'b1; end
    end
    if (!(d0 && d1)) begin
      total++; bad++;
      $display("FAIL issue_timeout: acks seen p0=%0d p1=%0d required both after %0d cycles", d0, d1, n);
      p0_req = 1'b0; p1_req = 1'b0;
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_e_n", 32'(mem_e_n), 32'd1);
    chk("rst_g_n", 32'(mem_g_n), 32'd1);
    chk("rst_w_n", 32'(mem_w_n), 32'd1);
    chk("rst_lb_n", 32'(mem_lb_n), 32'd1);
    chk("rst_ub_n", 32'(mem_ub_n), 32'd1);
    chk("rst_dq_oe", 32'(mem_dq_oe), 32'd0);
    chk("rst_mem_a", 32'(mem_a), 32'd0);
    chk("rst_dq_o", 32'(mem_dq_o), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_acks", 32'({p1_ack, p0_ack}), 32'd0);
  endtask

  initial begin : monitor
    exp_t x;
    int gcnt, wcnt;
    gcnt = 0; wcnt = 0;
    forever begin
      @(negedge SIM_CLK);
      if (!mem_e_n) e_low_cnt++;
      if (in_rst_test) begin
        gcnt = 0; wcnt = 0;
      end else begin
        if (!mem_g_n) gcnt++;
        else if (gcnt != 0) begin chk("g_pulse_len", 32'(gcnt), 32'(RD_WAIT)); gcnt = 0; end
        if (!mem_w_n) wcnt++;
        else if (wcnt != 0) begin chk("w_pulse_len", 32'(wcnt), 32'(WR_WAIT)); wcnt = 0; end
      end
      if (!mem_g_n || !mem_w_n) begin
        chk("gw_exclusive", 32'(mem_g_n | mem_w_n), 32'd1);
        chk("strobe_e_n_low", 32'(mem_e_n), 32'd0);
        chk("oe_matches_strobe", 32'(mem_dq_oe), 32'(!mem_w_n));
        chk("addr_hi_zero", 32'(mem_a[15:12]), 32'd0);
      end
      if (p0_ack || p1_ack) begin
        chk("ack_one_port", 32'(p0_ack & p1_ack), 32'd0);
        chk("ack_recovery_e_n", 32'({mem_e_n, mem_dq_oe}), 32'b10);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: p0_ack=%0d p1_ack=%0d with nothing outstanding", p0_ack, p1_ack);
        end else begin
          x = exp_q.pop_front();
          chk("ack_port", 32'(p1_ack), 32'(x.port));
          chk("ack_cycle", 32'(cyc), 32'(x.cyc));
          if (x.chk_rd) chk("ack_rdata", 32'(rdata), 32'(x.rd));
        end
      end
    end
  end

  initial begin : main
    txn_t a, b;
    int el, mode;
    repeat (3) @(negedge SIM_CLK);
    chk_reset_state();
    SIM_RST = 1'b0;

    issue(1'b1, 1'b0, mk(1'b1, 2'b11, 12'h012, 16'hBEEF), mk(1'b0, 2'b00, 12'h0, 16'h0), 1'b0);
    issue(1'b0, 1'b1, mk(1'b0, 2'b00, 12'h0, 16'h0), mk(1'b0, 2'b11, 12'h012, 16'h0), 1'b0);
    issue(1'b1, 1'b0, mk(1'b1, 2'b01, 12'h012, 16'h1234), mk(1'b0, 2'b00, 12'h0, 16'h0), 1'b0);
    issue(1'b0, 1'b1, mk(1'b0, 2'b00, 12'h0, 16'h0), mk(1'b0, 2'b11, 12'h012, 16'h0), 1'b0);
    chk("rmw_chip_word", 32'(chip_mem[12'h012]), 32'h0000BE34);

    for (int i = 0; i < 4; i++) begin
      a = rnd_txn();
      b = rnd_txn();
      issue(1'b1, 1'b1, a, b, 1'b0);
    end

    el = e_low_cnt;
    issue(1'b1, 1'b0, mk(1'b1, 2'b00, 12'h012, 16'hFFFF), mk(1'b0, 2'b00, 12'h0, 16'h0), 1'b0);
    chk("nop_no_e_n_activity", 32'(e_low_cnt - el), 32'd0);
    issue(1'b1, 1'b0, mk(1'b0, 2'b11, 12'h012, 16'h0), mk(1'b0, 2'b00, 12'h0, 16'h0), 1'b0);

    // reset lands in the middle of a read's G_n pulse
    in_rst_test = 1'b1;
    @(negedge SIM_CLK);
    p1_we = 1'b0; p1_be = 2'b11; p1_addr = 12'h012; p1_req = 1'b1;
    repeat (2) @(negedge SIM_CLK);
    chk("rst_mid_in_acc", 32'(mem_g_n), 32'd0);
    SIM_RST = 1'b1;
    @(negedge SIM_CLK);
    chk_reset_state();
    p1_req = 1'b0;
    SIM_RST = 1'b0;
    m_last = 1'b1;
    repeat (3) @(negedge SIM_CLK);
    in_rst_test = 1'b0;
    issue(1'b0, 1'b1, mk(1'b0, 2'b00, 12'h0, 16'h0), mk(1'b0, 2'b11, 12'h012, 16'h0), 1'b0);
    issue(1'b1, 1'b1, mk(1'b0, 2'b11, 12'h012, 16'h0), mk(1'b1, 2'b10, 12'h012, 16'hA5C3), 1'b0);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      a = rnd_txn();
      b = rnd_txn();
      issue(mode != 1, mode != 0, a, b, (mode != 2) && ($urandom_range(0, 1) == 1));
    end

    repeat (3) @(negedge SIM_CLK);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 16; i < 24; i++) chk("final_chip_word", 32'(chip_mem[i]), 32'(mem_ref[i]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
